fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Parametrised successor to the two-operand combinational forwarding unit for the 5-stage pipelined core.
- Owns its own destination-tag pipeline (EX, MEM, WB) instead of taking stage registers as inputs.
- Computes registered forwarding selects for NUM_SRC source operands and detects load-use hazards with a configurable load latency, driving the pipeline stall.
- Keeps saturating stall and forward performance counters.
- Sits beside the ID/EX boundary; the datapath muxes consume ex_fwd_sel in EX.

Parameters:
REG_AW, 5, register address width
NUM_SRC, 2, source operands per instruction (1..4)
LOAD_LAT, 1, load-use stall depth in cycles (1 or 2)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID-stage instruction valid
id_rs  in  NUM_SRC*REG_AW  source register addresses, operand i at bits [i*REG_AW +: REG_AW]
id_rs_used  in  NUM_SRC  per-operand use mask
id_rd  in  REG_AW  destination register of the ID instruction
id_regwrite  in  1  ID instruction writes rd
id_memread  in  1  ID instruction is a load
flush  in  1  branch/jump flush of the ID instruction
stall  out  1  hold PC and IF/ID; combinational
ex_fwd_sel  out  2*NUM_SRC  registered per-operand select
ex_valid, mem_valid, wb_valid  out  1 each  tag-pipeline valid bits
ex_rd, mem_rd, wb_rd  out  REG_AW each  tag-pipeline destinations
stall_cnt  out  CNT_W  saturating count of stall cycles
fwd_cnt  out  CNT_W  saturating count of non-zero operand selects issued

Behaviour:
- Reset: all stage valid, regwrite and memread bits are 0; rd tags are 0; ex_fwd_sel is 0; both counters are 0; stall is 0.
- Tag pipeline advances every clock: WB <= MEM, MEM <= EX.
  - EX <= ID tuple when id_valid & !stall & !flush.
  - Otherwise EX receives a bubble: valid=0, regwrite=0, memread=0, rd=0.
- Operand i is "live" when id_valid & id_rs_used[i] & id_rs[i]!=0.
- A stage S "matches" operand i when S.valid & S.regwrite & S.rd!=0 & S.rd==id_rs[i]. Register 0 never forwards.
- Select for operand i is computed in ID and registered into ex_fwd_sel on the same edge EX loads. Priority, youngest first:
  - EX match -> 2'b10, EX/MEM forward next cycle.
  - else MEM match -> 2'b01, MEM/WB forward.
  - else WB match -> 2'b11, WB write-through captured in ID.
  - else 2'b00, register file.
  - A non-live operand always gets 2'b00.
- Load-use stall, combinational, over the live operands:
  - asserted when EX.memread & EX match;
  - also asserted when LOAD_LAT==2 & MEM.memread & MEM match.
  - Resulting stall length: LOAD_LAT cycles behind an adjacent load; 1 cycle when a single independent instruction sits between them and LOAD_LAT==2.
- flush has priority: stall is forced to 0 when flush=1, and EX gets a bubble.
- During stall, ex_fwd_sel loads 0 with the bubble. The held instruction re-evaluates its selects each cycle against the advanced tags.
- Counters:
  - stall_cnt += 1 each cycle stall=1.
  - fwd_cnt += popcount of non-zero selects loaded into ex_fwd_sel.
  - Both saturate at all-ones and never wrap.
- Reset mid-stall: next cycle all tags are invalid and stall=0.
- Simultaneous match in EX and MEM for the same operand: EX wins. A load in EX with a non-load match in MEM still stalls.
- Latency: ex_fwd_sel is valid one cycle after the ID instruction is accepted, aligned with ex_valid.

Test Plan:
1. Reset, then ID add x3 (rs=x1,x2), then ID sub rs1=x3: second instruction gets ex_fwd_sel[1:0]=10, operand 1 =00; fwd_cnt=1.
2. Chain add x5 / nop / use x5 -> select 01; with two nops -> 11; with three nops -> 00.
3. LOAD_LAT=1: lw x4 then add rs1=x4 -> stall=1 for exactly 1 cycle, bubble in EX (ex_valid=0), then select 01; stall_cnt=1.
4. LOAD_LAT=2: lw x4 then use x4 -> 2 stall cycles then select 11. lw x4, independent op, use x4 -> 1 stall then 11.
5. Zero/mask: add x0 then use x0 -> 00, no stall. rs matches EX but id_rs_used=0 -> 00. flush asserted during a load-use stall -> stall=0, EX bubble.
6. Reset asserted during a stall -> all valids 0, counters 0. Force 2^CNT_W+3 stall cycles (CNT_W=4 build) -> stall_cnt holds 4'hF.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard unit with its own EX/MEM/WB tag pipeline; selects are registered one cycle.
// Backpressure: a combinational stall holds PC and IF/ID while EX takes bubbles, until the load result can be forwarded.
module fwd_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]   id_rs,
    input  logic [NUM_SRC-1:0]          id_rs_used,
    input  logic [REG_AW-1:0]           id_rd,
    input  logic                        id_regwrite,
    input  logic                        id_memread,
    input  logic                        flush,
    output logic                        stall,
    output logic [2*NUM_SRC-1:0]        ex_fwd_sel,
    output logic                        ex_valid,
    output logic                        mem_valid,
    output logic                        wb_valid,
    output logic [REG_AW-1:0]           ex_rd,
    output logic [REG_AW-1:0]           mem_rd,
    output logic [REG_AW-1:0]           wb_rd,
    output logic [CNT_W-1:0]            stall_cnt,
    output logic [CNT_W-1:0]            fwd_cnt
);

    logic                   ex_valid_q, ex_valid_d;
    logic                   ex_regwrite_q, ex_regwrite_d;
    logic                   ex_memread_q, ex_memread_d;
    logic [REG_AW-1:0]      ex_rd_q, ex_rd_d;
    logic                   mem_valid_q, mem_regwrite_q, mem_memread_q;
    logic [REG_AW-1:0]      mem_rd_q;
    logic                   wb_valid_q, wb_regwrite_q;
    logic [REG_AW-1:0]      wb_rd_q;
    logic [2*NUM_SRC-1:0]   ex_fwd_sel_q, ex_fwd_sel_d;
    logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]       fwd_cnt_q, fwd_cnt_d;

    logic [REG_AW-1:0]      rs_a [NUM_SRC];
    logic [NUM_SRC-1:0]     live, ex_match, mem_match, wb_match;
    logic [2*NUM_SRC-1:0]   sel_raw;
    logic                   load_hit;
    logic                   accept;
    logic [CNT_W:0]         fwd_inc;
    logic [CNT_W:0]         fwd_sum;

    always_comb begin
        sel_raw  = '0;
        load_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rs_a[i]      = id_rs[i*REG_AW +: REG_AW];
            live[i]      = id_valid & id_rs_used[i] & (rs_a[i] != '0);
            ex_match[i]  = ex_valid_q & ex_regwrite_q & (ex_rd_q != '0) & (ex_rd_q == rs_a[i]);
            mem_match[i] = mem_valid_q & mem_regwrite_q & (mem_rd_q != '0) & (mem_rd_q == rs_a[i]);
            wb_match[i]  = wb_valid_q & wb_regwrite_q & (wb_rd_q != '0) & (wb_rd_q == rs_a[i]);
            // Youngest producer wins; WB value is captured in ID as a write-through.
            if (live[i]) begin
                if (ex_match[i])       sel_raw[2*i +: 2] = 2'b10;
                else if (mem_match[i]) sel_raw[2*i +: 2] = 2'b01;
                else if (wb_match[i])  sel_raw[2*i +: 2] = 2'b11;
                else                   sel_raw[2*i +: 2] = 2'b00;
            end
            if (live[i] & ex_match[i] & ex_memread_q) load_hit = 1'b1;
            if ((LOAD_LAT == 2) && live[i] && mem_match[i] && mem_memread_q) load_hit = 1'b1;
        end
    end

    assign stall  = load_hit & ~flush & ~reset;
    assign accept = id_valid & ~stall & ~flush;

    always_comb begin
        ex_valid_d    = 1'b0;
        ex_regwrite_d = 1'b0;
        ex_memread_d  = 1'b0;
        ex_rd_d       = '0;
        ex_fwd_sel_d  = '0;
        if (accept) begin
            ex_valid_d    = 1'b1;
            ex_regwrite_d = id_regwrite;
            ex_memread_d  = id_memread;
            ex_rd_d       = id_rd;
            ex_fwd_sel_d  = sel_raw;
        end
    end

    always_comb begin
        fwd_inc = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            fwd_inc = fwd_inc + {{CNT_W{1'b0}}, (ex_fwd_sel_d[2*i +: 2] != 2'b00)};
        end
        fwd_sum   = {1'b0, fwd_cnt_q} + fwd_inc;
        fwd_cnt_d = (fwd_sum > {1'b0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : fwd_sum[CNT_W-1:0];
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q     <= 1'b0;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            ex_rd_q        <= '0;
            mem_valid_q    <= 1'b0;
            mem_regwrite_q <= 1'b0;
            mem_memread_q  <= 1'b0;
            mem_rd_q       <= '0;
            wb_valid_q     <= 1'b0;
            wb_regwrite_q  <= 1'b0;
            wb_rd_q        <= '0;
            ex_fwd_sel_q   <= '0;
            stall_cnt_q    <= '0;
            fwd_cnt_q      <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_regwrite_q  <= ex_regwrite_d;
            ex_memread_q   <= ex_memread_d;
            ex_rd_q        <= ex_rd_d;
            mem_valid_q    <= ex_valid_q;
            mem_regwrite_q <= ex_regwrite_q;
            mem_memread_q  <= ex_memread_q;
            mem_rd_q       <= ex_rd_q;
            wb_valid_q     <= mem_valid_q;
            wb_regwrite_q  <= mem_regwrite_q;
            wb_rd_q        <= mem_rd_q;
            ex_fwd_sel_q   <= ex_fwd_sel_d;
            stall_cnt_q    <= stall_cnt_d;
            fwd_cnt_q      <= fwd_cnt_d;
        end
    end

    assign ex_fwd_sel = ex_fwd_sel_q;
    assign ex_valid   = ex_valid_q;
    assign mem_valid  = mem_valid_q;
    assign wb_valid   = wb_valid_q;
    assign ex_rd      = ex_rd_q;
    assign mem_rd     = mem_rd_q;
    assign wb_rd      = wb_rd_q;
    assign stall_cnt  = stall_cnt_q;
    assign fwd_cnt    = fwd_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: one LOAD_LAT=1/CNT_W=4 instance and one LOAD_LAT=2/CNT_W=16 instance share stimulus.
module tb_fwd_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, id_valid, id_regwrite, id_memread, flush;
    logic [9:0] id_rs;
    logic [1:0] id_rs_used;
    logic [4:0] id_rd;

    logic       a_stall, a_ex_valid, a_mem_valid, a_wb_valid;
    logic [3:0] a_sel, a_stall_cnt, a_fwd_cnt;
    logic [4:0] a_ex_rd, a_mem_rd, a_wb_rd;
    logic       b_stall, b_ex_valid, b_mem_valid, b_wb_valid;
    logic [3:0] b_sel;
    logic [15:0] b_stall_cnt, b_fwd_cnt;
    logic [4:0] b_ex_rd, b_mem_rd, b_wb_rd;

    fwd_hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(4)) dut_a (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .stall(a_stall), .ex_fwd_sel(a_sel), .ex_valid(a_ex_valid), .mem_valid(a_mem_valid),
        .wb_valid(a_wb_valid), .ex_rd(a_ex_rd), .mem_rd(a_mem_rd), .wb_rd(a_wb_rd),
        .stall_cnt(a_stall_cnt), .fwd_cnt(a_fwd_cnt));

    fwd_hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(2), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .stall(b_stall), .ex_fwd_sel(b_sel), .ex_valid(b_ex_valid), .mem_valid(b_mem_valid),
        .wb_valid(b_wb_valid), .ex_rd(b_ex_rd), .mem_rd(b_mem_rd), .wb_rd(b_wb_rd),
        .stall_cnt(b_stall_cnt), .fwd_cnt(b_fwd_cnt));

    logic        use_b;
    logic        m_stall, m_ex_valid, m_mem_valid, m_wb_valid;
    logic [3:0]  m_sel;
    logic [15:0] m_stall_cnt, m_fwd_cnt;
    int          cnt_max;

    always_comb begin
        m_stall     = use_b ? b_stall     : a_stall;
        m_ex_valid  = use_b ? b_ex_valid  : a_ex_valid;
        m_mem_valid = use_b ? b_mem_valid : a_mem_valid;
        m_wb_valid  = use_b ? b_wb_valid  : a_wb_valid;
        m_sel       = use_b ? b_sel       : a_sel;
        m_stall_cnt = use_b ? b_stall_cnt : {12'b0, a_stall_cnt};
        m_fwd_cnt   = use_b ? b_fwd_cnt   : {12'b0, a_fwd_cnt};
        cnt_max     = use_b ? 65535 : 15;
    end

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [3:0] exp_q[$];
    int         exp_fwd;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int nz_fields(input logic [3:0] s);
        int c = 0;
        if (s[1:0] != 2'b00) c++;
        if (s[3:2] != 2'b00) c++;
        return c;
    endfunction

    function automatic int sat(input int v);
        return (v > cnt_max) ? cnt_max : v;
    endfunction

    // Scoreboard: every instruction entering EX must match the oldest pushed select.
    always @(negedge clk) begin
        if (!reset && m_ex_valid) begin
            if (exp_q.size() == 0) check_eq("sb_unexpected_ex", m_ex_valid, 0);
            else check_eq("ex_fwd_sel", m_sel, exp_q.pop_front());
        end
    end

    task automatic idle_inputs();
        id_valid = 0; id_rs = '0; id_rs_used = '0; id_rd = '0;
        id_regwrite = 0; id_memread = 0; flush = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; idle_inputs();
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_stall", m_stall, 0);
        check_eq("rst_valids", {m_ex_valid, m_mem_valid, m_wb_valid}, 0);
        check_eq("rst_sel", m_sel, 0);
        check_eq("rst_cnts", {m_stall_cnt, m_fwd_cnt}, 0);
        reset = 0;
        exp_q.delete();
        exp_fwd = 0;
    endtask

    task automatic issue(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [1:0] used, input logic [4:0] rd, input logic rw,
                         input logic mr, input logic [3:0] esel, input int estall);
        int n = 0;
        @(negedge clk);
        id_valid = 1; id_rs = {rs2, rs1}; id_rs_used = used; id_rd = rd;
        id_regwrite = rw; id_memread = mr;
        #1;
        while (m_stall && n < 8) begin
            n++;
            @(negedge clk); #1;
            check_eq({tag, "_bubble"}, m_ex_valid, 0);
        end
        check_eq({tag, "_stalls"}, n, estall);
        exp_q.push_back(esel);
        exp_fwd += nz_fields(esel);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic nop();
        @(posedge clk); #1;
    endtask

    task automatic hold_use_x4();
        @(negedge clk);
        id_valid = 1; id_rs = {5'd0, 5'd4}; id_rs_used = 2'b01; id_rd = 5'd9;
        id_regwrite = 0; id_memread = 0;
        #1;
        check_eq("hold_stall", m_stall, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1; use_b = 0; exp_fwd = 0; idle_inputs();

        // EX forward of the immediately preceding add.
        do_reset();
        issue("add3", 5'd1, 5'd2, 2'b11, 5'd3, 1, 0, 4'b0000, 0);
        issue("sub",  5'd3, 5'd2, 2'b11, 5'd6, 1, 0, 4'b0010, 0);
        check_eq("fwd_cnt_t1", m_fwd_cnt, sat(exp_fwd));

        // MEM, WB and register-file distance.
        issue("add5a", 5'd1, 5'd0, 2'b01, 5'd5, 1, 0, 4'b0000, 0);
        nop();
        issue("use5a", 5'd5, 5'd0, 2'b01, 5'd9, 0, 0, 4'b0001, 0);
        issue("add5b", 5'd1, 5'd0, 2'b01, 5'd5, 1, 0, 4'b0000, 0);
        nop(); nop();
        issue("use5b", 5'd0, 5'd5, 2'b10, 5'd9, 0, 0, 4'b1100, 0);
        issue("add5c", 5'd1, 5'd0, 2'b01, 5'd5, 1, 0, 4'b0000, 0);
        nop(); nop(); nop();
        issue("use5c", 5'd5, 5'd5, 2'b11, 5'd9, 0, 0, 4'b0000, 0);
        check_eq("fwd_cnt_t2", m_fwd_cnt, sat(exp_fwd));

        // Single-cycle load-use stall.
        do_reset();
        issue("lw_a",   5'd0, 5'd0, 2'b00, 5'd4, 1, 1, 4'b0000, 0);
        issue("use_a",  5'd4, 5'd0, 2'b01, 5'd9, 0, 0, 4'b0001, 1);
        check_eq("stall_cnt_t3", m_stall_cnt, 1);
        check_eq("fwd_cnt_t3", m_fwd_cnt, sat(exp_fwd));

        // Two-cycle load latency.
        use_b = 1;
        do_reset();
        issue("lw_b1",  5'd0, 5'd0, 2'b00, 5'd4, 1, 1, 4'b0000, 0);
        issue("use_b1", 5'd4, 5'd0, 2'b01, 5'd9, 0, 0, 4'b0011, 2);
        issue("lw_b2",  5'd0, 5'd0, 2'b00, 5'd4, 1, 1, 4'b0000, 0);
        issue("ind_b2", 5'd1, 5'd0, 2'b01, 5'd7, 1, 0, 4'b0000, 0);
        issue("use_b2", 5'd0, 5'd4, 2'b10, 5'd9, 0, 0, 4'b1100, 1);
        check_eq("stall_cnt_t4", m_stall_cnt, 3);
        check_eq("fwd_cnt_t4", m_fwd_cnt, sat(exp_fwd));

        // x0, use mask and flush.
        use_b = 0;
        do_reset();
        issue("add0",  5'd1, 5'd0, 2'b01, 5'd0, 1, 0, 4'b0000, 0);
        issue("use0",  5'd0, 5'd0, 2'b11, 5'd9, 0, 0, 4'b0000, 0);
        issue("add6",  5'd1, 5'd0, 2'b01, 5'd6, 1, 0, 4'b0000, 0);
        issue("mask6", 5'd6, 5'd6, 2'b00, 5'd9, 0, 0, 4'b0000, 0);
        issue("lw_f",  5'd0, 5'd0, 2'b00, 5'd4, 1, 1, 4'b0000, 0);
        hold_use_x4();
        flush = 1;
        #1;
        check_eq("flush_stall", m_stall, 0);
        @(posedge clk); #1;
        idle_inputs();
        check_eq("flush_bubble", {m_ex_valid, m_mem_valid}, 2'b01);
        check_eq("flush_sel", m_sel, 0);
        check_eq("flush_stall_cnt", m_stall_cnt, 0);

        // Reset while a stall is pending.
        issue("lw_r", 5'd0, 5'd0, 2'b00, 5'd4, 1, 1, 4'b0000, 0);
        hold_use_x4();
        reset = 1;
        @(posedge clk); #1;
        check_eq("midrst_valids", {m_ex_valid, m_mem_valid, m_wb_valid}, 0);
        check_eq("midrst_stall", m_stall, 0);
        check_eq("midrst_cnts", {m_stall_cnt, m_fwd_cnt}, 0);
        reset = 0;
        idle_inputs();
        exp_q.delete();
        exp_fwd = 0;

        // Counter saturation on the 4-bit build.
        do_reset();
        for (int k = 0; k < 19; k++) begin
            issue("lw_s",  5'd0, 5'd0, 2'b00, 5'd4, 1, 1, 4'b0000, 0);
            issue("use_s", 5'd4, 5'd0, 2'b01, 5'd9, 0, 0, 4'b0001, 1);
        end
        check_eq("stall_cnt_sat", m_stall_cnt, sat(19));
        check_eq("fwd_cnt_sat", m_fwd_cnt, sat(exp_fwd));

        @(negedge clk); @(negedge clk);
        check_eq("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
